prog_counter: RTL

PROG_COUNTER -- requirements
Module: prog_counter

---
 rtl/prog_counter.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/prog_counter.sv
// ---------------------------------------------------------------------------
// prog_counter
//
// Programmable up/down counter with three terminal-count behaviours:
//   mode 00 / 11 : wrap      (up -> 0, down -> limit at terminal)
//   mode 01      : saturate  (hold at terminal, flag every attempt)
//   mode 10      : one-shot  (IDLE -> RUN on load, RUN -> DONE at terminal)
//
// Priority each cycle is load > enable > hold. "Terminal" means
// count >= limit when counting up and count == 0 when counting down. limit
// and up_dn are used live, with no internal copy.
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   load       in   load data_in into count (wins over enable)
//   data_in    in   [WIDTH] load value, may exceed limit
//   enable     in   advance count by one step
//   up_dn      in   1 = count up, 0 = count down
//   mode       in   [2] counting behaviour, see above
//   limit      in   [WIDTH] inclusive upper terminal value
//   clr_flags  in   clears ovf (a same-cycle set wins)
//   count      out  [WIDTH] registered count
//   tc         out  one-cycle pulse after every terminal step
//   ovf        out  sticky overflow/underflow flag
//   done       out  one-shot finished (mode 10 only)
// ---------------------------------------------------------------------------
module prog_counter #(
  parameter int WIDTH   = 8,
  parameter int RST_VAL = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             enable,
  input  logic             up_dn,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] limit,
  input  logic             clr_flags,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf,
  output logic             done
);

  localparam logic [1:0]       MODE_SAT     = 2'b01;
  localparam logic [1:0]       MODE_ONESHOT = 2'b10;
  localparam logic [WIDTH-1:0] RST_VAL_W    = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE_W        = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic             terminal;
  logic             term_hit;   // an enabled step was attempted at terminal
  logic [WIDTH-1:0] step_val;

  // A value loaded above limit is terminal for the next up step.
  assign terminal = up_dn ? (count_q >= limit) : (count_q == '0);
  assign step_val = up_dn ? (count_q + ONE_W) : (count_q - ONE_W);

  always_comb begin
    count_d  = count_q;
    state_d  = state_q;
    term_hit = 1'b0;

    if (load) begin
      // Load never steps and never raises tc/ovf, even with enable high.
      count_d = data_in;
      if (mode == MODE_ONESHOT) begin
        state_d = S_RUN;
      end
    end else if (enable) begin
      case (mode)
        MODE_SAT: begin
          if (terminal) begin
            term_hit = 1'b1;
          end else begin
            count_d = step_val;
          end
        end
        MODE_ONESHOT: begin
          // IDLE and DONE ignore enable entirely.
          if (state_q == S_RUN) begin
            if (terminal) begin
              term_hit = 1'b1;
              state_d  = S_DONE;
            end else begin
              count_d = step_val;
            end
          end
        end
        default: begin
          // Wrap; the reserved encoding behaves identically.
          if (terminal) begin
            term_hit = 1'b1;
            count_d  = up_dn ? '0 : limit;
          end else begin
            count_d = step_val;
          end
        end
      endcase
    end

    // Leaving one-shot mode aborts any run in progress.
    if (mode != MODE_ONESHOT) begin
      state_d = S_IDLE;
    end

    tc_d   = term_hit;
    // Setting ovf takes precedence over a same-cycle clear.
    ovf_d  = term_hit | (ovf_q & ~clr_flags);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      count_q <= RST_VAL_W;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
      done_q  <= done_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;
  assign done  = done_q;

endmodule
